regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 8 +
 rtl/regfile_sb.sv | 83 ++++++++
 tb/tb_regfile_sb.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared CPU constants for the register file and its pending-producer scoreboard.
package regfile_sb_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write bypass and a per-register pending
// scoreboard; register 0 is hardwired to zero and never pending.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              mark,
    input  logic [ADDR_W-1:0] maddr,
    output logic              busy1,
    output logic              busy2
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(RF_ZERO_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic              wr_ok;
    logic              mk_ok;

    assign wr_ok = we && (waddr != ZERO);
    assign mk_ok = mark && (maddr != ZERO);

    // Clear on write first, then set on mark, so a same-register collision stays pending.
    always_comb begin
        pending_next = pending;
        if (wr_ok)
            pending_next[waddr] = 1'b0;
        if (mk_ok)
            pending_next[maddr] = 1'b1;
        pending_next[RF_ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pending <= '0;
        end else begin
            if (wr_ok)
                regs[waddr] <= wdata;
            pending <= pending_next;
        end
    end

    // Read value seen by a port: same-cycle write wins, r0 reads zero, reset forces zero.
    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] ra);
        if (!rst_n || ra == ZERO)
            return '0;
        if (wr_ok && ra == waddr)
            return wdata;
        return regs[ra];
    endfunction

    // A same-cycle write resolves the hazard unless a new producer is marked on that register.
    function automatic logic read_busy(input logic [ADDR_W-1:0] ra);
        if (!rst_n || ra == ZERO)
            return 1'b0;
        if (wr_ok && ra == waddr && !(mk_ok && ra == maddr))
            return 1'b0;
        return pending[ra];
    endfunction

    always_comb begin
        rdata1 = read_data(raddr1);
        rdata2 = read_data(raddr2);
        busy1  = read_busy(raddr1);
        busy2  = read_busy(raddr2);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        mark;
    logic [4:0]  maddr;
    logic        busy1;
    logic        busy2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    logic        m_pend [32];

    regfile_sb dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .mark   (mark),
        .maddr  (maddr),
        .busy1  (busy1),
        .busy2  (busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, want finished");
        $fatal(1);
    end

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Architectural effect of one rising edge given the inputs held across it.
    function automatic void model_edge();
        if (!rst_n)
            return;
        if (we && waddr != 0) begin
            m_regs[waddr] = wdata;
            m_pend[waddr] = 1'b0;
        end
        if (mark && maddr != 0)
            m_pend[maddr] = 1'b1;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!rst_n || a == 0)
            return 32'h0;
        if (we && waddr == a)
            return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        logic written;
        logic remarked;
        if (!rst_n || a == 0)
            return 1'b0;
        written  = we && waddr == a;
        remarked = mark && maddr == a;
        if (written && !remarked)
            return 1'b0;
        return m_pend[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we   = 1'b0;
        mark = 1'b0;
    endtask

    task automatic test_reset();
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
        mark = 1'b1; maddr = 5'd7;
        raddr1 = 5'd5; raddr2 = 5'd7;
        tick();
        idle();
        #2;
        n_checks++;
        if (rdata1 !== 32'h1234) begin
            n_fail++;
            $display("FAIL reset_preload: rdata1 got %h want %h", rdata1, 32'h1234);
        end
        n_checks++;
        if (busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preload_busy: busy2 got %b want 1", busy2);
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async_data: rdata1 got %h want 0", rdata1);
        end
        n_checks++;
        if (busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_busy: busy2 got %b want 0", busy2);
        end
        // Traffic during reset must be ignored, including the bypass path.
        we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_0000;
        mark = 1'b1; maddr = 5'd5;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ignores_we: rdata1/busy1 got %h/%b want 0/0", rdata1, busy1);
        end
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        tick();
        idle();
        #2;
        n_checks++;
        if (rdata1 !== 32'hFFFF_0000 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_write: rdata1/busy1 got %h/%b want ffff0000/1", rdata1, busy1);
        end
        raddr2 = 5'd7;
        #1;
        n_checks++;
        if (busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cleared_pending: busy2 got %b want 0", busy2);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd31; wdata = 32'hDEAD_BEEF; raddr1 = 5'd31;
        #2;
        n_checks++;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_bypass: rdata1 got %h want deadbeef", rdata1);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_stored: rdata1 got %h want deadbeef", rdata1);
        end
    endtask

    task automatic test_r0();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
        mark = 1'b1; maddr = 5'd0;
        #2;
        n_checks++;
        if (rdata1 !== 32'h0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_same_cycle: rdata1/busy1 got %h/%b want 0/0", rdata1, busy1);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (rdata1 !== 32'h0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_next_cycle: rdata1/busy1 got %h/%b want 0/0", rdata1, busy1);
        end
    endtask

    task automatic test_scoreboard();
        mark = 1'b1; maddr = 5'd8;
        tick();
        idle();
        raddr2 = 5'd8;
        #2;
        n_checks++;
        if (busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_marked: busy2 got %b want 1", busy2);
        end
        we = 1'b1; waddr = 5'd8; wdata = 32'd7;
        #2;
        n_checks++;
        if (busy2 !== 1'b0 || rdata2 !== 32'd7) begin
            n_fail++;
            $display("FAIL sb_resolve: busy2/rdata2 got %b/%h want 0/7", busy2, rdata2);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (busy2 !== 1'b0 || rdata2 !== 32'd7) begin
            n_fail++;
            $display("FAIL sb_cleared: busy2/rdata2 got %b/%h want 0/7", busy2, rdata2);
        end
        // Writing an already-clear register keeps it clear.
        we = 1'b1; waddr = 5'd8; wdata = 32'd9;
        tick();
        idle();
        #2;
        n_checks++;
        if (busy2 !== 1'b0 || rdata2 !== 32'd9) begin
            n_fail++;
            $display("FAIL sb_clear_write: busy2/rdata2 got %b/%h want 0/9", busy2, rdata2);
        end
    endtask

    task automatic test_collision();
        mark = 1'b1; maddr = 5'd9;
        tick();
        raddr1 = 5'd9;
        mark = 1'b1; maddr = 5'd9;
        we = 1'b1; waddr = 5'd9; wdata = 32'd3;
        #2;
        n_checks++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_same_cycle: busy1 got %b want 1", busy1);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (busy1 !== 1'b1 || rdata1 !== 32'd3) begin
            n_fail++;
            $display("FAIL collide_next: busy1/rdata1 got %b/%h want 1/3", busy1, rdata1);
        end
        // Mark and write on different registers act independently.
        mark = 1'b1; maddr = 5'd10;
        we = 1'b1; waddr = 5'd9; wdata = 32'd4;
        tick();
        idle();
        raddr2 = 5'd10;
        #2;
        n_checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b1 || rdata1 !== 32'd4) begin
            n_fail++;
            $display("FAIL split_mark_write: busy1/busy2/rdata1 got %b/%b/%h want 0/1/4",
                     busy1, busy2, rdata1);
        end
    endtask

    task automatic test_dual_port();
        we = 1'b1; waddr = 5'd12; wdata = 32'hA5A5_A5A5;
        tick();
        idle();
        raddr1 = 5'd12; raddr2 = 5'd12;
        #2;
        n_checks++;
        if (rdata1 !== 32'hA5A5_A5A5 || rdata2 !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL dual_data: rdata1/rdata2 got %h/%h want a5a5a5a5", rdata1, rdata2);
        end
        n_checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_busy: busy1/busy2 got %b/%b want 0/0", busy1, busy2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we     = ($urandom_range(0, 3) != 0);
            waddr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wdata  = $urandom;
            mark   = ($urandom_range(0, 2) == 0);
            maddr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? maddr : 5'($urandom);
            #2;
            n_checks++;
            if (rdata1 !== exp_data(raddr1) || rdata2 !== exp_data(raddr2)) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: rdata1/rdata2 got %h/%h want %h/%h",
                         n, rdata1, rdata2, exp_data(raddr1), exp_data(raddr2));
            end
            n_checks++;
            if (busy1 !== exp_busy(raddr1) || busy2 !== exp_busy(raddr2)) begin
                n_fail++;
                $display("FAIL rand_busy[%0d]: busy1/busy2 got %b/%b want %b/%b",
                         n, busy1, busy2, exp_busy(raddr1), exp_busy(raddr2));
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        mark = 1'b0; maddr = '0;
        raddr1 = '0; raddr2 = '0;
        model_clear();
        #12;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_write_read();
        test_r0();
        test_scoreboard();
        test_collision();
        test_dual_port();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
